// File: rtl/lcd_hd44780_driver_pkg.sv
// Shared definitions for the HD44780 driver: command codes, init ROM, state encoding.
package lcd_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_t;

    localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] DISP_ON         = 8'h0C;
    localparam logic [7:0] CLEAR           = 8'h01;
    localparam logic [7:0] ENTRY_INC       = 8'h06;
    localparam logic [7:0] HOME            = 8'h02;

    localparam int INIT_LEN = 6;

    // Function set is repeated three times so the controller locks into 8-bit mode
    // regardless of the interface width it woke up in.
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        FUNC_8BIT_2LINE, FUNC_8BIT_2LINE, FUNC_8BIT_2LINE,
        DISP_ON, CLEAR, ENTRY_INC
    };

    // Counter width able to hold max_val-1; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// Request handshake from the line writer plus the LCD panel pins.
interface lcd_hd44780_driver_if;
    logic [7:0] chr;
    logic       write_char;
    logic       home;
    logic       ready;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    // Line writer side
    modport master (
        output chr, write_char, home,
        input  ready, lcd_data, lcd_rs, lcd_rw, lcd_e
    );

    // Driver side
    modport slave (
        input  chr, write_char, home,
        output ready, lcd_data, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_hd44780_driver_bus_cycle.sv
// One timed HD44780 write cycle: SETUP -> PULSE -> HOLD -> EXEC.
// state | meaning
// IDLE  | no cycle in flight, waiting for i_start
// SETUP | data/RS driven, E low
// PULSE | E high
// HOLD  | E low, data/RS still held
// EXEC  | controller busy executing; done on the last cycle
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 25,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2_500,
    parameter int T_LONG  = 100_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_long,
    output logic       o_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_e
);

    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (T_HOLD > T_SHORT) ? T_HOLD : T_SHORT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > T_LONG) ? MAX_C : T_LONG;
    localparam int CNT_W = cnt_width(MAX_T);

    lcd_state_t       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_long;
    logic             r_e;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // done is combinational so the caller can chain the next cycle or raise ready
    // on the same edge EXEC expires, with no dead cycle in between.
    assign o_done     = (r_phase == EXEC) && w_cnt_zero;
    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_e    = r_e;

    // Phase sequencer: each phase loads its count minus one and advances at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_long  <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            case (r_phase)
                IDLE: begin
                    if (i_start) begin
                        r_data  <= i_data;
                        r_rs    <= i_rs;
                        r_long  <= i_long;
                        r_cnt   <= CNT_W'(T_SETUP - 1);
                        r_phase <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b1;
                        r_cnt   <= CNT_W'(T_PULSE - 1);
                        r_phase <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b0;
                        r_cnt   <= CNT_W'(T_HOLD - 1);
                        r_phase <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_long ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
                        r_phase <= EXEC;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (w_cnt_zero) begin
                        if (i_start) begin
                            r_data  <= i_data;
                            r_rs    <= i_rs;
                            r_long  <= i_long;
                            r_cnt   <= CNT_W'(T_SETUP - 1);
                            r_phase <= SETUP;
                        end else begin
                            r_phase <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_e     <= 1'b0;
                    r_phase <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit bus driver: power-up wait, init sequence, then one bus cycle per request.
// state   | meaning
// POWERUP | waiting T_POWERUP cycles after reset
// INIT    | issuing the six-entry init ROM back to back
// IDLE    | serving line-writer requests; ready=1 when no cycle is in flight
module lcd_hd44780_driver
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 2_000_000,
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 25,
    parameter int T_HOLD    = 2,
    parameter int T_SHORT   = 2_500,
    parameter int T_LONG    = 100_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    lcd_hd44780_driver_if.slave   io_bus
);

    localparam int PWR_W = cnt_width(T_POWERUP);

    lcd_state_t       r_state;
    logic [PWR_W-1:0] r_pwr_cnt;
    logic [2:0]       r_idx;
    logic             r_ready;

    logic       w_done;
    logic       w_accept;
    logic       w_pwr_last;
    logic       w_init_last;
    logic [2:0] w_next_idx;
    logic       w_start;
    logic [7:0] w_data;
    logic       w_rs;
    logic       w_long;
    logic [7:0] w_lcd_data;
    logic       w_lcd_rs;
    logic       w_lcd_e;

    assign w_accept    = (r_state == IDLE) && r_ready && (io_bus.write_char || io_bus.home);
    assign w_pwr_last  = (r_pwr_cnt == PWR_W'(T_POWERUP - 1));
    assign w_init_last = (r_idx == 3'(INIT_LEN - 1));
    assign w_next_idx  = r_idx + 3'd1;

    // Select what the bus cycle engine should start on this edge, if anything.
    always_comb begin
        w_start = 1'b0;
        w_data  = 8'h00;
        w_rs    = 1'b0;
        w_long  = 1'b0;
        case (r_state)
            POWERUP: begin
                if (w_pwr_last) begin
                    w_start = 1'b1;
                    w_data  = INIT_ROM[0];
                    w_long  = (INIT_ROM[0] == CLEAR);
                end
            end
            INIT: begin
                if (w_done && !w_init_last) begin
                    w_start = 1'b1;
                    w_data  = INIT_ROM[w_next_idx];
                    w_long  = (INIT_ROM[w_next_idx] == CLEAR);
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    if (io_bus.home) begin
                        // home wins over a simultaneous char; the char is dropped
                        w_data = HOME;
                        w_rs   = 1'b0;
                        w_long = 1'b1;
                    end else begin
                        w_data = io_bus.chr;
                        w_rs   = 1'b1;
                        w_long = 1'b0;
                    end
                end
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Top sequencer; the power-up timer counts up from the cleared reset value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= POWERUP;
            r_pwr_cnt <= '0;
            r_idx     <= 3'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                POWERUP: begin
                    if (w_pwr_last) begin
                        r_idx   <= 3'd0;
                        r_state <= INIT;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (w_done) begin
                        if (w_init_last) begin
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= w_next_idx;
                        end
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                    end else if (!r_ready && w_done) begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= POWERUP;
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG)
    ) u_bus_cycle (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_start),
        .i_data     (w_data),
        .i_rs       (w_rs),
        .i_long     (w_long),
        .o_done     (w_done),
        .o_lcd_data (w_lcd_data),
        .o_lcd_rs   (w_lcd_rs),
        .o_lcd_e    (w_lcd_e)
    );

    assign io_bus.ready    = r_ready;
    assign io_bus.lcd_data = w_lcd_data;
    assign io_bus.lcd_rs   = w_lcd_rs;
    assign io_bus.lcd_rw   = 1'b0;
    assign io_bus.lcd_e    = w_lcd_e;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver using small timing parameters.
module tb_lcd_hd44780_driver;

    localparam int P_POWERUP = 20;
    localparam int P_SETUP   = 1;
    localparam int P_PULSE   = 3;
    localparam int P_HOLD    = 1;
    localparam int P_SHORT   = 5;
    localparam int P_LONG    = 12;
    localparam int LOW_SHORT = P_SETUP + P_PULSE + P_HOLD + P_SHORT;   // 10
    localparam int LOW_LONG  = P_SETUP + P_PULSE + P_HOLD + P_LONG;    // 17
    localparam int FIRST_RDY = P_POWERUP + 5 * LOW_SHORT + LOW_LONG;   // 87

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lcd_hd44780_driver_if bus_if ();

    lcd_hd44780_driver #(
        .T_POWERUP (P_POWERUP),
        .T_SETUP   (P_SETUP),
        .T_PULSE   (P_PULSE),
        .T_HOLD    (P_HOLD),
        .T_SHORT   (P_SHORT),
        .T_LONG    (P_LONG)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor: logs {rs,data} at each E rise, E-high width at each fall,
    // and counts data/RS changes while E is high.
    logic [8:0] pulse_q [$];
    int         width_q [$];
    logic       prev_e = 1'b0;
    int         w_cnt = 0;
    int         unstable = 0;
    always @(negedge clk) begin
        if (bus_if.lcd_e && !prev_e) begin
            pulse_q.push_back({bus_if.lcd_rs, bus_if.lcd_data});
            w_cnt = 1;
        end else if (bus_if.lcd_e) begin
            w_cnt = w_cnt + 1;
            if (pulse_q.size() > 0 && pulse_q[pulse_q.size()-1] != {bus_if.lcd_rs, bus_if.lcd_data})
                unstable = unstable + 1;
        end else if (prev_e) begin
            width_q.push_back(w_cnt);
        end
        prev_e = bus_if.lcd_e;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        pulse_q.delete();
        width_q.delete();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus_if.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Hold reset, check cleared outputs, release, then check init timing and commands.
    task automatic reset_and_init(input string tag);
        logic [7:0] init_exp [6];
        int n;
        init_exp = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_rst_outs"}, {bus_if.ready, bus_if.lcd_e, bus_if.lcd_rs, bus_if.lcd_rw, bus_if.lcd_data}, 32'd0);
        clear_log();
        rst = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus_if.ready) break;
        end
        check({tag, "_first_ready"}, n, FIRST_RDY);
        check({tag, "_init_count"}, pulse_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pulse_q.size()) check({tag, "_init_cmd"}, pulse_q[i], {1'b0, init_exp[i]});
            if (i < width_q.size()) check({tag, "_init_width"}, width_q[i], P_PULSE);
        end
        check({tag, "_rw"}, bus_if.lcd_rw, 1'b0);
    endtask

    typedef struct {
        string      name;
        logic       wc;
        logic       hm;
        logic [7:0] ch;
        logic [7:0] exp_data;
        logic       exp_rs;
        int         exp_low;
    } vec_t;

    vec_t vecs [5];

    // Line-writer style request: assert, drop once ready is seen low.
    task automatic send(input logic wc, input logic hm, input logic [7:0] ch);
        wait_ready("send");
        bus_if.chr = ch;
        bus_if.write_char = wc;
        bus_if.home = hm;
        @(negedge clk);
        bus_if.write_char = 1'b0;
        bus_if.home = 1'b0;
    endtask

    initial begin
        string line;
        int low, e_at, n;
        bus_if.chr = 8'h00;
        bus_if.write_char = 1'b0;
        bus_if.home = 1'b0;

        vecs[0] = '{"char41", 1'b1, 1'b0, 8'h41, 8'h41, 1'b1, LOW_SHORT};
        vecs[1] = '{"home",   1'b0, 1'b1, 8'h5A, 8'h02, 1'b0, LOW_LONG};
        vecs[2] = '{"both",   1'b1, 1'b1, 8'h55, 8'h02, 1'b0, LOW_LONG};
        vecs[3] = '{"char00", 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, LOW_SHORT};
        vecs[4] = '{"charFF", 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, LOW_SHORT};

        reset_and_init("por");

        for (int v = 0; v < 5; v++) begin
            wait_ready(vecs[v].name);
            clear_log();
            bus_if.chr = vecs[v].ch;
            bus_if.write_char = vecs[v].wc;
            bus_if.home = vecs[v].hm;
            @(negedge clk);
            check({vecs[v].name, "_ready_drop"}, bus_if.ready, 1'b0);
            check({vecs[v].name, "_setup_data"}, {bus_if.lcd_e, bus_if.lcd_rs, bus_if.lcd_data},
                  {1'b0, vecs[v].exp_rs, vecs[v].exp_data});
            bus_if.write_char = 1'b0;
            bus_if.home = 1'b0;
            low = 1;
            e_at = 0;
            for (int k = 2; k < 200; k++) begin
                @(negedge clk);
                if (bus_if.lcd_e && e_at == 0) e_at = k;
                if (bus_if.ready) break;
                low++;
            end
            check({vecs[v].name, "_ready_low"}, low, vecs[v].exp_low);
            check({vecs[v].name, "_e_rise"}, e_at, P_SETUP + 1);
            repeat (3) @(negedge clk);
            check({vecs[v].name, "_pulses"}, pulse_q.size(), 1);
            if (pulse_q.size() > 0) check({vecs[v].name, "_cycle"}, pulse_q[0], {vecs[v].exp_rs, vecs[v].exp_data});
            if (width_q.size() > 0) check({vecs[v].name, "_width"}, width_q[0], P_PULSE);
        end

        // Requests while busy are ignored.
        wait_ready("busy");
        clear_log();
        send(1'b1, 1'b0, 8'h33);
        repeat (2) @(negedge clk);
        bus_if.chr = 8'h44;
        bus_if.write_char = 1'b1;
        @(negedge clk);
        bus_if.write_char = 1'b0;
        @(negedge clk);
        bus_if.home = 1'b1;
        @(negedge clk);
        bus_if.home = 1'b0;
        wait_ready("busy");
        repeat (5) @(negedge clk);
        check("busy_pulses", pulse_q.size(), 1);
        if (pulse_q.size() > 0) check("busy_cycle", pulse_q[0], {1'b1, 8'h33});
        check("busy_idle_ready", bus_if.ready, 1'b1);

        // Full line followed by home.
        line = "AAAABBBBCCCCABCD";
        clear_log();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, line[i]);
        send(1'b0, 1'b1, 8'h00);
        wait_ready("line");
        repeat (2) @(negedge clk);
        check("line_count", pulse_q.size(), 17);
        for (int i = 0; i < 16; i++)
            if (i < pulse_q.size()) check("line_char", pulse_q[i], {1'b1, line[i]});
        if (pulse_q.size() > 16) check("line_home", pulse_q[16], {1'b0, 8'h02});
        check("line_stable", unstable, 0);

        // Reset while E is high.
        send(1'b1, 1'b0, 8'h58);
        n = 0;
        while (!bus_if.lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_e_high", bus_if.lcd_e, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_e_drop", bus_if.lcd_e, 1'b0);
        check("midrst_ready", bus_if.ready, 1'b0);
        reset_and_init("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
